// File: rtl/fetch_pc_unit.sv
// Instruction-fetch PC stage.
// Owns the PC, issues req/ack reads to instruction memory, buffers one
// fetched word toward decode with a one-entry skid for decode stalls, and
// applies branch/jump redirects while squashing in-flight fetches.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | out of reset, no request outstanding; first request next
// ST_FETCH | request outstanding at imem_addr (== pc), waiting for ack
// ST_HOLD  | word parked in skid, decode stalled, no request outstanding
// ST_DRAIN | squashed request still outstanding; its data is discarded
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_taken,
  input  logic [31:0] br_pc4,
  input  logic [31:0] br_offset_sh,
  input  logic        jmp,
  input  logic [25:0] jmp_index,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc4_q, if_pc4_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;

  logic        redirect;
  logic [31:0] br_tgt;
  logic [31:0] jmp_tgt;
  logic [31:0] redir_tgt;
  logic        ack_vld;
  logic        slot_free;
  logic [31:0] pc_inc;

  // Redirect target selection; jump wins over a simultaneous branch.
  always_comb begin
    redirect  = jmp | br_taken;
    br_tgt    = br_pc4 + br_offset_sh;
    jmp_tgt   = {br_pc4[31:28], jmp_index, 2'b00};
    redir_tgt = jmp ? jmp_tgt : br_tgt;
    // An ack without an outstanding request (e.g. after reset) is stray.
    ack_vld   = imem_ack & imem_req_q;
    // The output slot can take a new word if empty or consumed this edge.
    slot_free = ~if_valid_q | ~stall;
    pc_inc    = pc_q + 32'd4;
  end

  // Next-state and next-output computation for the fetch FSM.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    imem_req_d   = imem_req_q;
    imem_addr_d  = imem_addr_q;
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc4_d     = if_pc4_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;

    // Decode takes the current word at this edge.
    if (if_valid_q && !stall) begin
      if_valid_d = 1'b0;
    end

    // A redirect kills whatever is buffered, in every state.
    if (redirect) begin
      if_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        state_d    = ST_FETCH;
        imem_req_d = 1'b1;
        if (redirect) begin
          pc_d        = redir_tgt;
          imem_addr_d = redir_tgt;
        end else begin
          imem_addr_d = pc_q;
        end
      end

      ST_FETCH: begin
        if (redirect) begin
          pc_d = redir_tgt;
          if (ack_vld) begin
            // Returning word belongs to the old path; start the target now.
            state_d     = ST_FETCH;
            imem_req_d  = 1'b1;
            imem_addr_d = redir_tgt;
          end else begin
            // Request must stay stable until its ack, so wait it out.
            state_d = ST_DRAIN;
          end
        end else if (ack_vld) begin
          pc_d = pc_inc;
          if (slot_free) begin
            if_valid_d  = 1'b1;
            if_instr_d  = imem_rdata;
            if_pc4_d    = imem_addr_q + 32'd4;
            imem_req_d  = 1'b1;
            imem_addr_d = pc_inc;
          end else begin
            skid_valid_d = 1'b1;
            skid_instr_d = imem_rdata;
            skid_pc4_d   = imem_addr_q + 32'd4;
            imem_req_d   = 1'b0;
            state_d      = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          pc_d        = redir_tgt;
          imem_req_d  = 1'b1;
          imem_addr_d = redir_tgt;
          state_d     = ST_FETCH;
        end else if (!stall) begin
          // Current output is consumed this edge; promote the skid word.
          if_valid_d   = 1'b1;
          if_instr_d   = skid_instr_q;
          if_pc4_d     = skid_pc4_q;
          skid_valid_d = 1'b0;
          imem_req_d   = 1'b1;
          imem_addr_d  = pc_q;
          state_d      = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        if (ack_vld) begin
          // Old request retired; a redirect landing on the same edge
          // supplies the newest target directly.
          pc_d        = redirect ? redir_tgt : pc_q;
          imem_req_d  = 1'b1;
          imem_addr_d = redirect ? redir_tgt : pc_q;
          state_d     = ST_FETCH;
        end else if (redirect) begin
          pc_d = redir_tgt;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        imem_req_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= 32'h0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= 32'h0;
      if_pc4_q     <= 32'h0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= 32'h0;
      skid_pc4_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc4_q     <= if_pc4_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc4    = if_pc4_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, branch/jump redirects,
// decode stall with skid, squashed fetch drain, and mid-request reset.
module tb_fetch_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        br_taken;
  logic [31:0] br_pc4;
  logic [31:0] br_offset_sh;
  logic        jmp;
  logic [25:0] jmp_index;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;

  int n_checks = 0;
  int n_errors = 0;

  fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .br_taken     (br_taken),
    .br_pc4       (br_pc4),
    .br_offset_sh (br_offset_sh),
    .jmp          (jmp),
    .jmp_index    (jmp_index),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc4       (if_pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    br_taken     = 1'b0;
    br_pc4       = 32'h0;
    br_offset_sh = 32'h0;
    jmp          = 1'b0;
    jmp_index    = 26'h0;
    stall        = 1'b0;
    imem_ack     = 1'b0;
    imem_rdata   = 32'h0;
    #1;
    chk("rst_req",   {31'h0, imem_req}, 32'h0);
    chk("rst_addr",  imem_addr,         32'h0);
    chk("rst_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_instr", if_instr,          32'h0);
    chk("rst_pc4",   if_pc4,            32'h0);
    step();
    step();
    rst_n = 1'b1;

    // Test 1: sequential fetch, ack every cycle
    step();
    chk("t1_req0",   {31'h0, imem_req}, 32'h1);
    chk("t1_addr0",  imem_addr,         32'h0);
    chk("t1_valid0", {31'h0, if_valid}, 32'h0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1111_0000;
    step();
    chk("t1_valid1", {31'h0, if_valid}, 32'h1);
    chk("t1_instr1", if_instr,          32'h1111_0000);
    chk("t1_pc4_1",  if_pc4,            32'h4);
    chk("t1_addr1",  imem_addr,         32'h4);
    imem_rdata = 32'h1111_0004;
    step();
    chk("t1_pc4_2",  if_pc4,            32'h8);
    chk("t1_addr2",  imem_addr,         32'h8);
    imem_rdata = 32'h1111_0008;
    step();
    chk("t1_pc4_3",  if_pc4,            32'hC);
    chk("t1_addr3",  imem_addr,         32'hC);
    chk("t1_valid3", {31'h0, if_valid}, 32'h1);
    chk("t1_instr3", if_instr,          32'h1111_0008);

    // Test 2: branch coinciding with ack; returned word dropped
    imem_rdata   = 32'h1111_000C;
    br_taken     = 1'b1;
    br_pc4       = 32'h0000_0100;
    br_offset_sh = 32'h0001_FFFC;
    step();
    br_taken = 1'b0;
    imem_ack = 1'b0;
    chk("t2_valid", {31'h0, if_valid}, 32'h0);
    chk("t2_req",   {31'h0, imem_req}, 32'h1);
    chk("t2_addr",  imem_addr,         32'h0002_00FC);

    // Test 3: branch with no ack -> drain, then wrapped target
    br_taken     = 1'b1;
    br_pc4       = 32'h0001_0000;
    br_offset_sh = 32'hFFFF_7AB4;
    step();
    br_taken = 1'b0;
    chk("t3_hold_addr", imem_addr,         32'h0002_00FC);
    chk("t3_hold_req",  {31'h0, imem_req}, 32'h1);
    imem_ack   = 1'b1;
    imem_rdata = 32'h5555_5555;
    step();
    imem_ack = 1'b0;
    chk("t3_addr",  imem_addr,         32'h0000_7AB4);
    chk("t3_valid", {31'h0, if_valid}, 32'h0);

    // Test 4: jump and branch together, jump wins
    jmp          = 1'b1;
    br_taken     = 1'b1;
    br_pc4       = 32'hA000_0010;
    br_offset_sh = 32'h0000_0040;
    jmp_index    = 26'h012_3456;
    imem_ack     = 1'b1;
    step();
    jmp      = 1'b0;
    br_taken = 1'b0;
    imem_ack = 1'b0;
    chk("t4_addr",  imem_addr,         32'hA048_D158);
    chk("t4_valid", {31'h0, if_valid}, 32'h0);

    // Test 5: stall with occupied slot -> skid/HOLD, then release
    stall      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_0000;
    step();
    chk("t5_fill_valid", {31'h0, if_valid}, 32'h1);
    chk("t5_fill_instr", if_instr,          32'h1234_0000);
    chk("t5_fill_addr",  imem_addr,         32'hA048_D15C);
    imem_rdata = 32'hBEEF_0001;
    step();
    imem_ack = 1'b0;
    chk("t5_hold_req",   {31'h0, imem_req}, 32'h0);
    chk("t5_hold_instr", if_instr,          32'h1234_0000);
    chk("t5_hold_valid", {31'h0, if_valid}, 32'h1);
    step();
    chk("t5_hold2_req",  {31'h0, imem_req}, 32'h0);
    chk("t5_hold2_inst", if_instr,          32'h1234_0000);
    stall = 1'b0;
    step();
    chk("t5_rel_instr", if_instr,          32'hBEEF_0001);
    chk("t5_rel_pc4",   if_pc4,            32'hA048_D160);
    chk("t5_rel_valid", {31'h0, if_valid}, 32'h1);
    chk("t5_rel_req",   {31'h0, imem_req}, 32'h1);
    chk("t5_rel_addr",  imem_addr,         32'hA048_D160);

    // Test 6: redirect while pending, late ack discarded
    br_taken     = 1'b1;
    br_pc4       = 32'h0000_0040;
    br_offset_sh = 32'h0000_0000;
    step();
    br_taken = 1'b0;
    chk("t6_valid0", {31'h0, if_valid}, 32'h0);
    chk("t6_addr0",  imem_addr,         32'hA048_D160);
    step();
    step();
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_DEAD;
    step();
    imem_ack = 1'b0;
    chk("t6_valid1", {31'h0, if_valid}, 32'h0);
    chk("t6_req1",   {31'h0, imem_req}, 32'h1);
    chk("t6_addr1",  imem_addr,         32'h0000_0040);
    step();
    chk("t6_valid2", {31'h0, if_valid}, 32'h0);

    // Reset mid-request: immediate clear, late ack ignored afterwards
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req",   {31'h0, imem_req}, 32'h0);
    chk("t6_rst_addr",  imem_addr,         32'h0);
    chk("t6_rst_valid", {31'h0, if_valid}, 32'h0);
    chk("t6_rst_instr", if_instr,          32'h0);
    chk("t6_rst_pc4",   if_pc4,            32'h0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h7777_7777;
    step();
    rst_n = 1'b1;
    step();
    chk("t6_post_valid", {31'h0, if_valid}, 32'h0);
    chk("t6_post_req",   {31'h0, imem_req}, 32'h1);
    chk("t6_post_addr",  imem_addr,         32'h0);
    imem_ack = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
